// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word-organised memory with byte/halfword/word lanes,
// configurable wait states and the two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hselx,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    output logic [DATA_WIDTH-1:0] hrdata,
    output logic                  hreadyout,
    output logic                  hresp
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int LAT_W = IDX_W + 2;
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * 4);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    function automatic logic [3:0] lane_enable(input logic [1:0] offs, input logic [2:0] size);
        logic [3:0] be;
        case (size)
            3'b000:  be = 4'b0001 << offs;
            3'b001:  be = offs[1] ? 4'b1100 : 4'b0011;
            3'b010:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_word(input logic [DATA_WIDTH-1:0] old_word,
                                                         input logic [DATA_WIDTH-1:0] new_word,
                                                         input logic [3:0]            be);
        logic [DATA_WIDTH-1:0] m;
        m = old_word;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                m[8*k +: 8] = new_word[8*k +: 8];
            end else begin
                m[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return m;
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

    state_t                state_r, state_s;
    logic [3:0]            wcnt_r, wcnt_s;
    logic [LAT_W-1:0]      addr_r;
    logic                  write_r;
    logic [2:0]            size_r;
    logic [DATA_WIDTH-1:0] hrdata_r;
    logic                  hreadyout_r, hresp_r;

    logic                  accept_s, illegal_s, latch_s;
    logic                  commit_s, load_rd_s, rd_write_s;
    logic [IDX_W-1:0]      rd_idx_s, wr_idx_s;
    logic [DATA_WIDTH-1:0] wr_merged_s, rd_word_s;

    // Next-state, accept/legality decode, write merge and read forwarding
    always_comb begin
        accept_s  = hselx && hready && ((htrans == 2'b10) || (htrans == 2'b11));
        illegal_s = (hsize > 3'b010)
                 || ((hsize == 3'b001) && haddr[0])
                 || ((hsize == 3'b010) && (haddr[1:0] != 2'b00))
                 || ({1'b0, haddr} >= MEM_BYTES);
        state_s = state_r;
        wcnt_s  = wcnt_r;
        latch_s = 1'b0;
        case (state_r)
            ST_WAIT: begin
                if (wcnt_r <= 4'd1) begin
                    state_s = ST_DATA;
                    wcnt_s  = 4'd0;
                end else begin
                    wcnt_s  = wcnt_r - 4'd1;
                end
            end
            ST_ERR1: state_s = ST_ERR2;
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept_s) begin
                    latch_s = 1'b1;
                    if (illegal_s) begin
                        state_s = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_s = ST_WAIT;
                        wcnt_s  = 4'(WAIT_STATES);
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: state_s = ST_IDLE;
        endcase

        // Entering DATA from WAIT uses the latched phase; otherwise the live address phase
        commit_s    = (state_r == ST_DATA) && write_r;
        wr_idx_s    = addr_r[LAT_W-1:2];
        wr_merged_s = merge_word(mem_r[wr_idx_s], hwdata, lane_enable(addr_r[1:0], size_r));
        if (state_r == ST_WAIT) begin
            rd_idx_s   = addr_r[LAT_W-1:2];
            rd_write_s = write_r;
        end else begin
            rd_idx_s   = haddr[LAT_W-1:2];
            rd_write_s = hwrite;
        end
        load_rd_s = (state_s == ST_DATA) && !rd_write_s;
        if (commit_s && (rd_idx_s == wr_idx_s)) begin
            rd_word_s = wr_merged_s;
        end else begin
            rd_word_s = mem_r[rd_idx_s];
        end
    end

    // FSM, wait counter and registered response outputs
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_r     <= ST_IDLE;
            wcnt_r      <= 4'd0;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            wcnt_r      <= wcnt_s;
            hreadyout_r <= !((state_s == ST_WAIT) || (state_s == ST_ERR1));
            hresp_r     <= (state_s == ST_ERR1) || (state_s == ST_ERR2);
        end
    end

    // Address-phase capture and read data register
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            addr_r   <= {LAT_W{1'b0}};
            write_r  <= 1'b0;
            size_r   <= 3'b000;
            hrdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
            if (latch_s) begin
                addr_r  <= haddr[LAT_W-1:0];
                write_r <= hwrite;
                size_r  <= hsize;
            end
            if (load_rd_s) begin
                hrdata_r <= rd_word_s;
            end
        end
    end

    // Memory array: contents survive reset, written only at the end of a write DATA cycle
    always_ff @(posedge hclk) begin
        if (commit_s) begin
            mem_r[wr_idx_s] <= wr_merged_s;
        end
    end

    assign hrdata    = hrdata_r;
    assign hreadyout = hreadyout_r;
    assign hresp     = hresp_r;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench: two slaves (zero and two wait states) checked against an
// array-based memory model with per-transfer expected response and wait count.
module tb_ahb_sram_slave;
    typedef struct {
        bit          wr;
        logic [15:0] a;
        logic [2:0]  sz;
        logic [31:0] wd;
    } xfer_t;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        hselx0 = 1'b0, hselx1 = 1'b0, hwrite = 1'b0, stall = 1'b0;
    logic [15:0] haddr = 16'h0000;
    logic [1:0]  htrans = 2'b00;
    logic [2:0]  hsize = 3'b000;
    logic [31:0] hwdata = 32'h0;
    logic        hready0, hready1, hreadyout0, hreadyout1, hresp0, hresp1;
    logic [31:0] hrdata0, hrdata1;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] ref_mem [2][1024];
    logic [31:0] last_rd [2];
    xfer_t       pq[$];

    assign hready0 = hreadyout0 & ~stall;
    assign hready1 = hreadyout1 & ~stall;

    ahb_sram_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) dut0 (
        .hclk(hclk), .hresetn(hresetn), .hselx(hselx0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready0),
        .hrdata(hrdata0), .hreadyout(hreadyout0), .hresp(hresp0));

    ahb_sram_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(2)) dut1 (
        .hclk(hclk), .hresetn(hresetn), .hselx(hselx1), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready1),
        .hrdata(hrdata1), .hreadyout(hreadyout1), .hresp(hresp1));

    always #5 hclk = ~hclk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    function automatic logic rdy(input int d);
        return (d == 1) ? hreadyout1 : hreadyout0;
    endfunction
    function automatic logic rsp(input int d);
        return (d == 1) ? hresp1 : hresp0;
    endfunction
    function automatic logic [31:0] rdat(input int d);
        return (d == 1) ? hrdata1 : hrdata0;
    endfunction

    task automatic set_sel(input int d, input logic v);
        if (d == 1) hselx1 = v;
        else        hselx0 = v;
    endtask

    function automatic bit is_legal(input logic [15:0] a, input logic [2:0] sz);
        if (sz > 3'd2) return 1'b0;
        if (a % (16'd1 << sz) != 16'd0) return 1'b0;
        if (a >= 16'd4096) return 1'b0;
        return 1'b1;
    endfunction

    // Little-endian lane update: bytes a[1:0] .. a[1:0]+2**sz-1 of the word take hwdata
    function automatic void model_write(input int d, input logic [15:0] a, input logic [2:0] sz,
                                        input logic [31:0] wd);
        int base, nb;
        base = int'(a[1:0]);
        nb   = 1 << sz;
        for (int k = 0; k < 4; k++) begin
            if (k >= base && k < base + nb) ref_mem[d][a[11:2]][8*k +: 8] = wd[8*k +: 8];
        end
    endfunction

    // One non-pipelined transfer: address phase, then data phase until completion
    task automatic xfer(input int d, input bit wr, input logic [15:0] a, input logic [2:0] sz,
                        input logic [31:0] wd);
        int waits;
        haddr = a; hwrite = wr; hsize = sz; htrans = 2'b10; set_sel(d, 1'b1);
        tick();
        htrans = 2'b00; set_sel(d, 1'b0); hwdata = wd;
        if (!is_legal(a, sz)) begin
            check_val("err1_ready", 32'(rdy(d)), 32'd0);
            check_val("err1_resp", 32'(rsp(d)), 32'd1);
            check_val("err_hold", rdat(d), last_rd[d]);
            tick();
            check_val("err2_ready", 32'(rdy(d)), 32'd1);
            check_val("err2_resp", 32'(rsp(d)), 32'd1);
            tick();
        end else begin
            waits = 0;
            while (rdy(d) == 1'b0 && waits < 40) begin
                check_val("wait_resp", 32'(rsp(d)), 32'd0);
                check_val("wait_hold", rdat(d), last_rd[d]);
                waits++;
                tick();
            end
            check_val("wait_count", waits, (d == 1) ? 32'd2 : 32'd0);
            check_val("ok_resp", 32'(rsp(d)), 32'd0);
            if (wr) begin
                check_val("wr_hold", rdat(d), last_rd[d]);
            end else begin
                check_val("rd_data", rdat(d), ref_mem[d][a[11:2]]);
                last_rd[d] = ref_mem[d][a[11:2]];
            end
            tick();
            if (wr) model_write(d, a, sz, wd);
        end
    endtask

    // Back-to-back legal transfers on the zero-wait slave, one per cycle
    task automatic run_pipe();
        int n;
        n = pq.size();
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                haddr = pq[i].a; hwrite = pq[i].wr; hsize = pq[i].sz; htrans = 2'b10; hselx0 = 1'b1;
            end else begin
                htrans = 2'b00; hselx0 = 1'b0;
            end
            if (i > 0) begin
                hwdata = pq[i-1].wd;
                check_val("pipe_ready", 32'(hreadyout0), 32'd1);
                check_val("pipe_resp", 32'(hresp0), 32'd0);
                if (!pq[i-1].wr) begin
                    check_val("pipe_rd", hrdata0, ref_mem[0][pq[i-1].a[11:2]]);
                    last_rd[0] = ref_mem[0][pq[i-1].a[11:2]];
                end
            end
            tick();
            if (i > 0 && pq[i-1].wr) model_write(0, pq[i-1].a, pq[i-1].sz, pq[i-1].wd);
        end
        pq.delete();
    endtask

    function automatic xfer_t rand_legal(input int words);
        xfer_t x;
        logic [2:0] sz;
        logic [1:0] off;
        sz = 3'($urandom_range(0, 2));
        off = 2'($urandom_range(0, 3));
        if (sz == 3'd1) off[0] = 1'b0;
        if (sz == 3'd2) off = 2'b00;
        x.wr = 1'($urandom_range(0, 1));
        x.sz = sz;
        x.a  = 16'($urandom_range(0, words - 1) * 4) | {14'd0, off};
        x.wd = $urandom();
        return x;
    endfunction

    initial begin
        xfer_t x;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        repeat (3) @(posedge hclk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_val("rst_ready", 32'(rdy(d)), 32'd1);
            check_val("rst_resp", 32'(rsp(d)), 32'd0);
            check_val("rst_rdata", rdat(d), 32'h0);
        end
        hresetn = 1'b1;
        tick();

        // Fill both memories so every later read has a known model value
        for (int w = 0; w < 1024; w++) begin
            x.wr = 1'b1; x.a = 16'(w * 4); x.sz = 3'd2; x.wd = $urandom();
            pq.push_back(x);
        end
        run_pipe();
        for (int w = 0; w < 1024; w++) xfer(1, 1'b1, 16'(w * 4), 3'd2, $urandom());

        // Directed word, lane and forwarding cases on the zero-wait slave
        xfer(0, 1'b1, 16'h0010, 3'd2, 32'hDEADBEEF);
        xfer(0, 1'b0, 16'h0010, 3'd2, 32'h0);
        check_val("word_const", hrdata0, 32'hDEADBEEF);
        xfer(0, 1'b1, 16'h0020, 3'd2, 32'h11223344);
        xfer(0, 1'b1, 16'h0021, 3'd0, 32'h0000AA00);
        xfer(0, 1'b1, 16'h0022, 3'd1, 32'h55660000);
        xfer(0, 1'b0, 16'h0020, 3'd2, 32'h0);
        check_val("lane_const", hrdata0, 32'h5566AA44);
        x.wr = 1'b1; x.a = 16'h0030; x.sz = 3'd2; x.wd = 32'hCAFEF00D; pq.push_back(x);
        x.wr = 1'b0; x.wd = 32'h0; pq.push_back(x);
        run_pipe();
        check_val("fwd_const", hrdata0, 32'hCAFEF00D);

        // Error responses on both slaves, then confirm memory untouched
        for (int d = 0; d < 2; d++) begin
            xfer(d, 1'b0, 16'h0002, 3'd2, 32'h0);
            xfer(d, 1'b1, 16'h1000, 3'd2, 32'h12345678);
            xfer(d, 1'b1, 16'h0040, 3'd3, 32'h99999999);
            xfer(d, 1'b0, 16'h0FFC, 3'd2, 32'h0);
            xfer(d, 1'b0, 16'h0040, 3'd2, 32'h0);
            xfer(d, 1'b0, 16'h0000, 3'd2, 32'h0);
        end

        // No accept while stalled, on IDLE/BUSY, or when deselected
        stall = 1'b1;
        haddr = 16'h0050; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10; hselx1 = 1'b1;
        hwdata = 32'hBAD0BAD0;
        tick();
        tick();
        stall = 1'b0; hselx1 = 1'b0; htrans = 2'b00;
        check_val("stall_ready", 32'(hreadyout1), 32'd1);
        tick();
        check_val("stall_ready2", 32'(hreadyout1), 32'd1);
        check_val("stall_resp", 32'(hresp1), 32'd0);
        xfer(1, 1'b0, 16'h0050, 3'd2, 32'h0);
        hselx1 = 1'b1; htrans = 2'b00;
        tick();
        check_val("idle_ready", 32'(hreadyout1), 32'd1);
        htrans = 2'b01;
        tick();
        check_val("busy_ready", 32'(hreadyout1), 32'd1);
        hselx1 = 1'b0; htrans = 2'b10;
        tick();
        check_val("desel_ready", 32'(hreadyout1), 32'd1);
        check_val("desel_resp", 32'(hresp1), 32'd0);
        htrans = 2'b00;
        tick();

        // Reset in the middle of a wait state drops the write
        haddr = 16'h0100; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10; hselx1 = 1'b1;
        tick();
        htrans = 2'b00; hselx1 = 1'b0; hwdata = ~ref_mem[1][64];
        check_val("midwait_ready", 32'(hreadyout1), 32'd0);
        hresetn = 1'b0;
        #1;
        check_val("arst_ready", 32'(hreadyout1), 32'd1);
        check_val("arst_resp", 32'(hresp1), 32'd0);
        check_val("arst_rdata", hrdata1, 32'h0);
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        @(posedge hclk);
        #3;
        hresetn = 1'b1;
        tick();
        xfer(1, 1'b0, 16'h0100, 3'd2, 32'h0);

        // Randomised single transfers on both slaves, including illegal ones
        for (int i = 0; i < 400; i++) begin
            logic [2:0] sz;
            sz = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            xfer(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 16'($urandom_range(0, 4200)), sz, $urandom());
        end

        // Randomised back-to-back bursts over a small window to hit forwarding
        for (int p = 0; p < 10; p++) begin
            for (int j = 0; j < 20; j++) pq.push_back(rand_legal(8));
            run_pipe();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
